// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter, port A priority, port B queued (optional: REGFILE_WB_FWD_EN)
module regfile_wb_arbiter #(
  parameter int DATA_W       = 16,
  parameter int IDX_W        = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int MAX_IDX      = 10,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          aValid,
  input  logic [IDX_W-1:0]              aIndex,
  input  logic [DATA_W-1:0]             aData,
  output logic                          aReady,
  input  logic                          bValid,
  input  logic [IDX_W-1:0]              bIndex,
  input  logic [DATA_W-1:0]             bData,
  output logic                          bReady,
  output logic [IDX_W-1:0]              writeIndex,
  output logic [DATA_W-1:0]             dataToWrite,
  output logic [MAX_IDX:0]              pendingMask,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [IDX_W-1:0]              fwdIndex,
  output logic                          fwdHit,
  output logic [DATA_W-1:0]             fwdData
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [IDX_W-1:0]  entIdx  [FIFO_DEPTH];
  logic [DATA_W-1:0] entData [FIFO_DEPTH];
  logic [PTR_W-1:0]  headPtr, tailPtr;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starveCnt;
  logic [FIFO_DEPTH-1:0] slotValid;
  logic collision, starve, issueA, pop, push;

  // Index 0 and anything beyond the last architectural register mean "no write"
  function automatic logic isNull(input logic [IDX_W-1:0] idx);
    return (idx == '0) || (int'(idx) > MAX_IDX);
  endfunction

  // A slot is live when its distance from the head is below the occupancy
  always_comb begin
    slotValid = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slotValid[i] = {1'b0, PTR_W'(i) - headPtr} < count;
    end
  end

  // Search the queue for the hazard mask and for A-vs-queued-B same-register conflicts
  always_comb begin
    collision   = 1'b0;
    pendingMask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slotValid[i]) begin
        if (entIdx[i] == aIndex) collision = 1'b1;
        for (int r = 0; r <= MAX_IDX; r++) begin
          if (entIdx[i] == IDX_W'(r)) pendingMask[r] = 1'b1;
        end
      end
    end
    collision = collision && aValid && !isNull(aIndex);
  end

  assign starve    = (count != '0) && (starveCnt >= SC_W'(STARVE_LIMIT));
  assign aReady    = !collision && !starve;
  assign bReady    = count < CNT_W'(FIFO_DEPTH);
  assign issueA    = aValid && aReady;
  assign pop       = !issueA && (count != '0);
  assign push      = bValid && bReady && !isNull(bIndex);
  assign fifoCount = count;

  // Drive the register-file write port; it holds through the following negedge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeIndex  <= '0;
      dataToWrite <= '0;
    end else if (issueA) begin
      writeIndex  <= aIndex;
      dataToWrite <= aData;
    end else if (pop) begin
      writeIndex  <= entIdx[headPtr];
      dataToWrite <= entData[headPtr];
    end else begin
      writeIndex  <= '0;
    end
  end

  // Queue bookkeeping and the head-of-line wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      starveCnt <= '0;
    end else begin
      if (pop)  headPtr <= headPtr + 1'b1;
      if (push) tailPtr <= tailPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop || count == '0)
        starveCnt <= '0;
      else if (starveCnt < SC_W'(STARVE_LIMIT))
        starveCnt <= starveCnt + 1'b1;
    end
  end

  // Queue payload storage; liveness is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      entIdx[tailPtr]  <= bIndex;
      entData[tailPtr] <= bData;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  logic [PTR_W-1:0] fwdSlot;

  // Walk oldest to youngest so the youngest matching load wins
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    fwdSlot = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      fwdSlot = headPtr + PTR_W'(k);
      if (({1'b0, PTR_W'(k)} < count) && (entIdx[fwdSlot] == fwdIndex) && !isNull(fwdIndex)) begin
        fwdHit  = 1'b1;
        fwdData = entData[fwdSlot];
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        aValid, bValid;
  logic [3:0]  aIndex, bIndex;
  logic [15:0] aData, bData;
  logic        aReady, bReady;
  logic [3:0]  writeIndex;
  logic [15:0] dataToWrite;
  logic [10:0] pendingMask;
  logic [1:0]  fifoCount;
`ifdef REGFILE_WB_FWD_EN
  logic [3:0]  fwdIndex;
  logic        fwdHit;
  logic [15:0] fwdData;
`endif

  int nChecks = 0;
  int nErr    = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .aValid(aValid), .aIndex(aIndex), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bIndex(bIndex), .bData(bData), .bReady(bReady),
    .writeIndex(writeIndex), .dataToWrite(dataToWrite),
    .pendingMask(pendingMask), .fifoCount(fifoCount)
`ifdef REGFILE_WB_FWD_EN
    , .fwdIndex(fwdIndex), .fwdHit(fwdHit), .fwdData(fwdData)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queued B writes as a plain list, plus head wait count
  typedef struct { logic [3:0] idx; logic [15:0] data; } ent_t;
  ent_t q[$];
  int          mWait;
  logic [3:0]  mWI;
  logic [15:0] mWD;

  typedef struct {
    logic aV; logic [3:0] aI; logic [15:0] aD;
    logic bV; logic [3:0] bI; logic [15:0] bD;
    logic eAR; logic eBR; logic [1:0] eCnt; logic [10:0] eMask;
    logic [3:0] eWI; logic [15:0] eWD;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit nullIdx(input logic [3:0] idx);
    return (idx == 0) || (idx > 10);
  endfunction

  task automatic setIn(input logic av, input logic [3:0] ai, input logic [15:0] ad,
                       input logic bv, input logic [3:0] bi, input logic [15:0] bd);
    aValid = av; aIndex = ai; aData = ad;
    bValid = bv; bIndex = bi; bData = bd;
  endtask

  task automatic doReset();
    setIn(0, 0, 0, 0, 0, 0);
`ifdef REGFILE_WB_FWD_EN
    fwdIndex = 0;
`endif
    rst = 1'b0;
    q.delete(); mWait = 0; mWI = 0; mWD = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_count", fifoCount, 0);
    chk("rst_mask", pendingMask, 0);
    chk("rst_wi", writeIndex, 0);
    chk("rst_wd", dataToWrite, 0);
    chk("rst_bready", bReady, 1);
  endtask

  // One cycle against the reference model
  task automatic modelCycle(input logic av, input logic [3:0] ai, input logic [15:0] ad,
                            input logic bv, input logic [3:0] bi, input logic [15:0] bd);
    bit coll, expA, expB, popped;
    logic [10:0] mask;
    int sizeBefore;
    setIn(av, ai, ad, bv, bi, bd);
    #1;
    coll = 0; mask = 0;
    foreach (q[k]) begin
      mask[q[k].idx] = 1'b1;
      if (av && !nullIdx(ai) && q[k].idx == ai) coll = 1;
    end
    expA = !coll && !(q.size() > 0 && mWait >= 3);
    expB = q.size() < 2;
    chk("m_aready", aReady, expA);
    chk("m_bready", bReady, expB);
    chk("m_count", fifoCount, q.size());
    chk("m_mask", pendingMask, mask);
`ifdef REGFILE_WB_FWD_EN
    begin
      bit hit; logic [15:0] fd;
      hit = 0; fd = 0;
      foreach (q[k]) if (!nullIdx(fwdIndex) && q[k].idx == fwdIndex) begin hit = 1; fd = q[k].data; end
      chk("m_fwdhit", fwdHit, hit);
      if (hit) chk("m_fwddata", fwdData, fd);
    end
`endif
    sizeBefore = q.size();
    popped = 0;
    if (av && expA) begin
      mWI = ai; mWD = ad;
    end else if (q.size() > 0) begin
      mWI = q[0].idx; mWD = q[0].data;
      void'(q.pop_front());
      popped = 1;
    end else begin
      mWI = 0;
    end
    if (popped || sizeBefore == 0) mWait = 0;
    else if (mWait < 3) mWait++;
    if (bv && expB && !nullIdx(bi)) q.push_back('{bi, bd});
    @(posedge clk);
    #1;
    chk("m_wi", writeIndex, mWI);
    chk("m_wd", dataToWrite, mWD);
  endtask

  initial begin
    setIn(0, 0, 0, 0, 0, 0);
`ifdef REGFILE_WB_FWD_EN
    fwdIndex = 0;
`endif

    // Directed vectors: simultaneous requests, ordering collision, full/starve/null handling
    tbl[0]  = '{1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2,  16'hBBBB, 1'b1, 1'b1, 2'd0, 11'h000, 4'd1, 16'hAAAA};
    tbl[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 2'd1, 11'h004, 4'd2, 16'hBBBB};
    tbl[2]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5,  16'h0005, 1'b1, 1'b1, 2'd0, 11'h000, 4'd0, 16'hBBBB};
    tbl[3]  = '{1'b1, 4'd5, 16'h0050, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 2'd1, 11'h020, 4'd5, 16'h0005};
    tbl[4]  = '{1'b1, 4'd5, 16'h0050, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 2'd0, 11'h000, 4'd5, 16'h0050};
    tbl[5]  = '{1'b1, 4'd1, 16'h0101, 1'b1, 4'd3,  16'h0303, 1'b1, 1'b1, 2'd0, 11'h000, 4'd1, 16'h0101};
    tbl[6]  = '{1'b1, 4'd2, 16'h0202, 1'b1, 4'd6,  16'h0606, 1'b1, 1'b1, 2'd1, 11'h008, 4'd2, 16'h0202};
    tbl[7]  = '{1'b1, 4'd1, 16'h0111, 1'b1, 4'd7,  16'h0777, 1'b1, 1'b0, 2'd2, 11'h048, 4'd1, 16'h0111};
    tbl[8]  = '{1'b1, 4'd0, 16'hDEAD, 1'b1, 4'd0,  16'h0000, 1'b1, 1'b0, 2'd2, 11'h048, 4'd0, 16'hDEAD};
    tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 2'd2, 11'h048, 4'd3, 16'h0303};
    tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0,  16'h9999, 1'b1, 1'b1, 2'd1, 11'h040, 4'd6, 16'h0606};
    tbl[11] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd12, 16'h8888, 1'b1, 1'b1, 2'd0, 11'h000, 4'd0, 16'h0606};
    tbl[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 2'd0, 11'h000, 4'd0, 16'h0606};

    doReset();
    for (int i = 0; i < 13; i++) begin
      setIn(tbl[i].aV, tbl[i].aI, tbl[i].aD, tbl[i].bV, tbl[i].bI, tbl[i].bD);
      #1;
      chk($sformatf("v%0d_aready", i), aReady, tbl[i].eAR);
      chk($sformatf("v%0d_bready", i), bReady, tbl[i].eBR);
      chk($sformatf("v%0d_count", i), fifoCount, tbl[i].eCnt);
      chk($sformatf("v%0d_mask", i), pendingMask, tbl[i].eMask);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wi", i), writeIndex, tbl[i].eWI);
      chk($sformatf("v%0d_wd", i), dataToWrite, tbl[i].eWD);
    end

    // Reset arriving while a B write is still queued
    doReset();
    setIn(1, 1, 16'hAAAA, 1, 3, 16'h1111);
    @(posedge clk);
    #1;
    chk("rq_count_pre", fifoCount, 1);
    chk("rq_wi_pre", writeIndex, 1);
    setIn(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    chk("rq_count", fifoCount, 0);
    chk("rq_mask", pendingMask, 0);
    chk("rq_wi", writeIndex, 0);
    chk("rq_wd", dataToWrite, 0);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rq_nowrite", writeIndex, 0);
    end

    // Starvation: A keeps the port busy while R4 waits in the queue
    doReset();
    setIn(1, 1, 16'h0001, 1, 4, 16'h0444);
    @(posedge clk);
    #1;
    chk("sv_first", writeIndex, 1);
    for (int k = 0; k < 3; k++) begin
      setIn(1, 4'(k + 1), 16'(k), 0, 0, 0);
      #1;
      chk("sv_aready_wait", aReady, 1);
      @(posedge clk);
      #1;
      chk("sv_a_issue", writeIndex, 4'(k + 1));
    end
    setIn(1, 5, 16'h0555, 0, 0, 0);
    #1;
    chk("sv_aready_drop", aReady, 0);
    @(posedge clk);
    #1;
    chk("sv_forced_wi", writeIndex, 4);
    chk("sv_forced_wd", dataToWrite, 16'h0444);
    chk("sv_aready_back", aReady, 1);
    chk("sv_empty", fifoCount, 0);
    @(posedge clk);
    #1;
    chk("sv_a_after", writeIndex, 5);

`ifdef REGFILE_WB_FWD_EN
    // Forwarding picks the youngest queued load for a register
    doReset();
    modelCycle(1, 1, 16'h0001, 1, 7, 16'h1234);
    modelCycle(1, 2, 16'h0002, 1, 7, 16'h5678);
    fwdIndex = 7;
    #1;
    chk("fwd_hit7", fwdHit, 1);
    chk("fwd_data7", fwdData, 16'h5678);
    fwdIndex = 6;
    #1;
    chk("fwd_hit6", fwdHit, 0);
    fwdIndex = 0;
`endif

    // Randomized traffic against the reference model
    doReset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ai, bi;
      ai = ($urandom_range(0, 9) == 0) ? 4'd12 : 4'($urandom_range(0, 6));
      bi = ($urandom_range(0, 9) == 0) ? 4'd11 : 4'($urandom_range(0, 6));
`ifdef REGFILE_WB_FWD_EN
      fwdIndex = 4'($urandom_range(0, 7));
`endif
      modelCycle($urandom_range(0, 3) != 0, ai, 16'($urandom),
                 $urandom_range(0, 1) == 1, bi, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two write-back requesters. Port A is the ALU/EX result path and has priority. Port B is the memory-load path and is buffered in a small in-order FIFO.
- Preserves per-register write ordering.
- Prevents B starvation.
- Exports a pending-write mask to the hazard unit.
- Sits between the EX/MEM write-back stages and the register file's writeIndex/dataToWrite inputs.

Parameters:
DATA_W, 16, write data width
IDX_W, 4, register index width
FIFO_DEPTH, 2, port-B queue entries (power of 2, >=2)
MAX_IDX, 10, highest valid register index (R0-R7, IH=8, SP=9, RA=10)
STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may wait before forced drain

Ports:
clk  in  1  system clock; arbiter state updates on posedge
rst  in  1  asynchronous reset, active-low
aValid  in  1  port A write request
aIndex  in  IDX_W  port A destination register
aData  in  DATA_W  port A write data
aReady  out  1  port A accepted this cycle
bValid  in  1  port B write request
bIndex  in  IDX_W  port B destination register
bData  in  DATA_W  port B write data
bReady  out  1  port B can be accepted this cycle
writeIndex  out  IDX_W  to register file; 0 = no write
dataToWrite  out  DATA_W  to register file
pendingMask  out  MAX_IDX+1  bit i set = a queued (not yet issued) write targets register i
fifoCount  out  log2(FIFO_DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst low, async): FIFO emptied and queued writes discarded, also when reset arrives mid-operation. writeIndex=0, dataToWrite=0, starve counter=0, fifoCount=0, pendingMask=0.
- writeIndex and dataToWrite are registered on posedge and hold stable for the following negedge, which is when the register file writes. Issue latency is 1 posedge from acceptance for A, and at least 2 for B.
- Null index means index 0 or index > MAX_IDX.
  - Null A request: accepted (subject to aReady) and issues writeIndex=0.
  - Null B request: accepted when bReady and dropped; it is never pushed.
- collision = aValid and aIndex non-null and aIndex equals the index of any valid FIFO entry.
- starve = FIFO non-empty and starve counter >= STARVE_LIMIT.
- aReady = not collision and not starve (combinational).
- bReady = fifoCount < FIFO_DEPTH, computed from registered state. No same-cycle pop pass-through.
- Issue select each posedge:
  1. If aValid and aReady: issue A (writeIndex<=aIndex, dataToWrite<=aData).
  2. Else if FIFO non-empty: issue head and pop.
  3. Else: writeIndex<=0, dataToWrite holds its previous value.
- Push: bValid and bReady and bIndex non-null writes the tail.
- Push and pop in the same cycle is legal; fifoCount is unchanged.
- Starve counter: increments each posedge the FIFO is non-empty and not popped. Clears on pop or when the FIFO is empty. Saturates at STARVE_LIMIT.
- pendingMask = OR of one-hot(index) over valid FIFO entries; combinational from registered state.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Ordering guarantee: for any register, writes reach the register file in acceptance order across both ports.

Optional Feature:
Macro REGFILE_WB_FWD_EN.
- When defined, adds the following ports:
  - fwdIndex  in  IDX_W
  - fwdHit  out  1
  - fwdData  out  DATA_W
- fwdHit is set when any valid FIFO entry matches non-null fwdIndex. fwdData is the youngest matching entry's data. The path is combinational, for EX-stage forwarding of queued loads.
- When not defined, the ports are absent and the FIFO search logic is not built.

Test Plan:
1. Reset mid-queue: push B R3=0x1111, assert rst low before issue -> fifoCount=0, pendingMask=0, writeIndex=0 immediately (async); R3 is never written.
2. Simultaneous requests: A R1=0xAAAA and B R2=0xBBBB in the same cycle, FIFO empty -> edge 1 writeIndex=1/0xAAAA; edge 2 writeIndex=2/0xBBBB; pendingMask bit2 is high between those edges.
3. Ordering collision: B R5=0x0005 queued, then A R5=0x0050 -> aReady=0 until the FIFO entry issues; sequence is 5/0x0005 then 5/0x0050.
4. Starvation: B R4 queued, A valid every cycle with non-colliding indices -> after 3 waiting edges aReady drops for one cycle and writeIndex=4 issues; the counter then clears.
5. Full and null requests: two B pushes fill the FIFO -> bReady=0. A B request with bIndex=0 or 12 is accepted and dropped (fifoCount unchanged, no write). A request with aIndex=0 issues writeIndex=0.
6. REGFILE_WB_FWD_EN: queue B R7=0x1234 then B R7=0x5678, fwdIndex=7 -> fwdHit=1, fwdData=0x5678; fwdIndex=6 -> fwdHit=0.
